// File: rtl/mkgauss_pkg.sv
// Shared constants for the Falcon keygen Gaussian sampler: the gauss_1024_12289
// CDT table, FSM state type and logn clamp helper.
package mkgauss_pkg;

  localparam int GAUSS_N = 27;

  localparam logic [62:0] GAUSS_TBL [0:GAUSS_N-1] = '{
    63'd1283868770400643928, 63'd6416574995475331444, 63'd4078260278032692663,
    63'd2353523259288686585, 63'd1227179971273316331, 63'd575931623374121527,
    63'd242543240509105209,  63'd91437049221049666,   63'd30799446349977173,
    63'd9255276791179340,    63'd2478152334826140,    63'd590642893610164,
    63'd125206034929641,     63'd23590435911403,      63'd3948334035941,
    63'd586753615614,        63'd77391054539,         63'd9056793210,
    63'd940121950,           63'd86539696,            63'd7062824,
    63'd510971,              63'd32764,               63'd1862,
    63'd94,                  63'd4,                   63'd0
  };

  typedef enum logic [1:0] {IDLE, ACC, PUSH} state_t;

  function automatic logic [3:0] clamp_logn(input logic [3:0] logn, input logic [3:0] logn_max);
    if (logn == 4'd0) return 4'd1;
    if (logn > logn_max) return logn_max;
    return logn;
  endfunction

endpackage

// File: rtl/mkgauss_if.sv
// Stream bundle between the PRNG, the sampler and the coefficient writer.
interface mkgauss_if #(parameter int VAL_W = 32) ();
  logic                    rng_valid;
  logic [127:0]            rng;
  logic                    rng_extract;
  logic                    val_valid;
  logic                    val_ready;
  logic signed [VAL_W-1:0] val;

  modport master (input rng_valid, rng, val_ready, output rng_extract, val_valid, val);
  modport slave  (output rng_valid, rng, val_ready, input rng_extract, val_valid, val);
endinterface

// File: rtl/mkgauss_base_sampler.sv
// One base Gaussian sample from a 128-bit PRNG word (two u64 halves), combinational.
module mkgauss_base_sampler
  import mkgauss_pkg::*;
(
  input  logic [127:0]      rng,
  output logic signed [5:0] sample
);
  localparam logic [63:0] LOW63 = 64'h7FFF_FFFF_FFFF_FFFF;

  logic              neg;
  logic [63:0]       r0;
  logic [63:0]       r1;
  logic [4:0]        v;
  logic signed [5:0] mag;

  assign neg = rng[63];
  assign r0  = rng[63:0] & LOW63;
  assign r1  = rng[127:64] & LOW63;

  // Descending scan leaves the smallest qualifying index in v.
  always_comb begin
    v = 5'd0;
    for (int k = GAUSS_N - 1; k >= 1; k--) begin
      if (r1 >= {1'b0, GAUSS_TBL[k]}) v = 5'(k);
    end
    if (r0 < {1'b0, GAUSS_TBL[0]}) v = 5'd0;
  end

  assign mag    = $signed({1'b0, v});
  assign sample = neg ? -mag : mag;
endmodule

// File: rtl/mkgauss_stream.sv
// Streaming Gaussian sampler: sums 2^(LOGN_MAX-logn) base samples per output into a FIFO.
// Define MKGAUSS_PERF_EN to add the stall_cnt performance counter port.
module mkgauss_stream
  import mkgauss_pkg::*;
#(
  parameter int VAL_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LOGN_MAX   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] logn,
  mkgauss_if.master  bus,
  output logic       busy
`ifdef MKGAUSS_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = LOGN_MAX;

  state_t                  state_q, state_d;
  logic                    extract, start, push, pop, full;
  logic [3:0]              logn_c;
  logic [CNT_W-1:0]        g_m1_new, g_m1_q, cnt_q;
  logic signed [5:0]       sample;
  logic signed [VAL_W-1:0] sample_ext, acc_q;
  logic signed [VAL_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q;

  mkgauss_base_sampler u_base (.rng(bus.rng), .sample(sample));

  assign sample_ext = {{(VAL_W-6){sample[5]}}, sample};
  assign logn_c     = clamp_logn(logn, 4'(LOGN_MAX));
  assign g_m1_new   = CNT_W'((32'd1 << (4'(LOGN_MAX) - logn_c)) - 32'd1);
  assign full       = (count_q == (PTR_W+1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    extract = 1'b0;
    start   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: if (ena) begin
        state_d = ACC;
        start   = 1'b1;
      end
      ACC: begin
        extract = bus.rng_valid;
        if (bus.rng_valid && cnt_q == g_m1_q) state_d = PUSH;
      end
      PUSH: if (!full) begin
        push = 1'b1;
        if (ena) begin
          state_d = ACC;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) extract = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      g_m1_q <= '0;
    end else if (start) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      g_m1_q <= g_m1_new;
    end else if (extract) begin
      acc_q <= acc_q + sample_ext;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Full is registered, so a same-cycle pop only frees the slot for the next cycle.
  assign pop = bus.val_valid && bus.val_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= acc_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.rng_extract = extract;
  assign bus.val_valid   = (count_q != '0);
  assign bus.val         = mem_q[rd_ptr_q];
  assign busy            = (state_q != IDLE) || (count_q != '0);

`ifdef MKGAUSS_PERF_EN
  logic stall;
  assign stall = (state_q == ACC && !bus.rng_valid) || (state_q == PUSH && full);

  always_ff @(posedge clk) begin
    if (rst)                             stall_cnt <= '0;
    else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mkgauss_stream.sv
// Self-checking bench for mkgauss_stream: scoreboard model plus directed vectors.
`timescale 1ns/1ps
module tb_mkgauss_stream;
  localparam int VAL_W = 32;

  localparam logic [62:0] TBL [0:26] = '{
    63'd1283868770400643928, 63'd6416574995475331444, 63'd4078260278032692663,
    63'd2353523259288686585, 63'd1227179971273316331, 63'd575931623374121527,
    63'd242543240509105209,  63'd91437049221049666,   63'd30799446349977173,
    63'd9255276791179340,    63'd2478152334826140,    63'd590642893610164,
    63'd125206034929641,     63'd23590435911403,      63'd3948334035941,
    63'd586753615614,        63'd77391054539,         63'd9056793210,
    63'd940121950,           63'd86539696,            63'd7062824,
    63'd510971,              63'd32764,               63'd1862,
    63'd94,                  63'd4,                   63'd0
  };

  localparam logic [127:0] W_ONES  = {128{1'b1}};
  localparam logic [127:0] W_NEG2  = {1'b0, 63'd4078260278032692663, 1'b1, 63'd1283868770400643928};
  localparam logic [127:0] W_P26   = {1'b0, 63'd0, 1'b0, 63'd1283868770400643928};
  localparam logic [127:0] W_BELOW = {1'b1, 63'h7FFF_FFFF_FFFF_FFFF, 1'b1, 63'd1283868770400643927};
  localparam logic [127:0] W_K3    = {1'b0, 63'd4078260278032692662, 1'b0, 63'd5000000000000000000};

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [3:0] logn;
  logic       busy;
`ifdef MKGAUSS_PERF_EN
  logic [31:0] stall_cnt;
`endif

  mkgauss_if #(.VAL_W(VAL_W)) bus ();

  mkgauss_stream #(.VAL_W(VAL_W), .FIFO_DEPTH(4), .LOGN_MAX(10)) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .logn(logn),
    .bus(bus),
    .busy(busy)
`ifdef MKGAUSS_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int ext_cnt = 0;
  int m_g = 1;
  int m_n = 0;
  longint m_sum = 0;
  longint exp_q[$];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Value of one base sample straight from the CDT definition.
  function automatic int ref_sample(input logic [127:0] w);
    logic [63:0] a, b;
    int v;
    a = {1'b0, w[62:0]};
    b = {1'b0, w[126:64]};
    v = 0;
    if (a >= {1'b0, TBL[0]}) begin
      for (int k = 1; k < 27; k++) begin
        if (b >= {1'b0, TBL[k]}) begin
          v = k;
          break;
        end
      end
    end
    return w[63] ? -v : v;
  endfunction

  function automatic int g_of(input int l);
    int c;
    c = (l == 0) ? 1 : ((l > 10) ? 10 : l);
    return 1 << (10 - c);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      m_sum = 0;
      m_n   = 0;
      exp_q.delete();
    end else begin
      if (bus.rng_extract === 1'b1) begin
        ext_cnt++;
        check("extract_needs_valid", bus.rng_valid, 1);
        m_sum += ref_sample(bus.rng);
        m_n++;
        if (m_n == m_g) begin
          exp_q.push_back(m_sum);
          m_sum = 0;
          m_n   = 0;
        end
      end
      if (bus.val_valid === 1'b1 && bus.val_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL sb_val: got %0d, expected no value", bus.val);
        end else begin
          check("sb_val", bus.val, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (busy !== 1'b0) begin
      tests++;
      failed++;
      $display("FAIL drain_timeout: busy=%b, expected 0 within %0d cycles", busy, bound);
    end
    tick();
  endtask

  task automatic run_value(input string name, input logic [3:0] l, input logic [127:0] w,
                           input int exp_ext, input int exp_val);
    int e0, i;
    logn = l;
    m_g = g_of(int'(l));
    bus.rng = w;
    bus.rng_valid = 1'b1;
    bus.val_ready = 1'b1;
    e0 = ext_cnt;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    i = 0;
    @(negedge clk);
    while (bus.val_valid !== 1'b1 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check({name, "_val"}, bus.val, exp_val);
    wait_drain(100);
    check({name, "_ext"}, ext_cnt - e0, exp_ext);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst = 1'b1;
    ena = 1'b0;
    logn = 4'd10;
    bus.rng = '0;
    bus.rng_valid = 1'b0;
    bus.val_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_val_valid", bus.val_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_extract", bus.rng_extract, 0);
    check("rst_val", bus.val, 0);
    tick();

    // Single extract, zero word, exact latency.
    logn = 4'd10; m_g = 1; bus.rng = '0; bus.rng_valid = 1'b1; bus.val_ready = 1'b1;
    e0 = ext_cnt;
    ena = 1'b1; tick(); ena = 1'b0;
    @(negedge clk); check("t1_extract", bus.rng_extract, 1);
    @(negedge clk); check("t1_push_valid", bus.val_valid, 0); check("t1_push_extract", bus.rng_extract, 0);
    @(negedge clk); check("t1_valid", bus.val_valid, 1); check("t1_val", bus.val, 0);
    wait_drain(100);
    check("t1_ext", ext_cnt - e0, 1);

    run_value("ones10", 4'd10, W_ONES, 1, -1);
    run_value("ones9", 4'd9, W_ONES, 2, -2);
    run_value("neg2", 4'd10, W_NEG2, 1, -2);
    run_value("p26", 4'd10, W_P26, 1, 26);
    run_value("below", 4'd10, W_BELOW, 1, 0);
    run_value("k3x2", 4'd9, W_K3, 2, 6);
    run_value("clamp_hi", 4'd15, W_ONES, 1, -1);
    run_value("clamp_lo", 4'd0, W_ONES, 512, -512);

    // Backpressure: four queued, fifth held in PUSH.
    logn = 4'd10; m_g = 1; bus.rng = W_ONES; bus.rng_valid = 1'b1; bus.val_ready = 1'b0;
    e0 = ext_cnt;
    ena = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("full_ext", ext_cnt - e0, 5);
    check("full_no_extract", bus.rng_extract, 0);
    check("full_val_valid", bus.val_valid, 1);
    check("full_head", bus.val, -1);
    tick();
    bus.val_ready = 1'b1; tick(); bus.val_ready = 1'b0;
    @(negedge clk); check("full_push_wait", bus.rng_extract, 0);
    tick();
    @(negedge clk); check("full_resume", bus.rng_extract, 1);
    ena = 1'b0;
    tick();
    bus.val_ready = 1'b1;
    wait_drain(100);
    check("full_total_ext", ext_cnt - e0, 6);

    // Random words, random valid/ready gaps, logn=8.
    logn = 4'd8; m_g = 4; ena = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bus.rng = {$urandom, $urandom, $urandom, $urandom};
      bus.rng_valid = ($urandom_range(0, 3) != 0);
      bus.val_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    ena = 1'b0; bus.rng_valid = 1'b1; bus.val_ready = 1'b1;
    wait_drain(200);
    check("rand_sb_empty", exp_q.size(), 0);

    // Reset mid-value with one value sitting in the FIFO.
    logn = 4'd10; m_g = 1; bus.rng = W_ONES; bus.rng_valid = 1'b1; bus.val_ready = 1'b0;
    ena = 1'b1; tick(); ena = 1'b0;
    repeat (3) tick();
    logn = 4'd8; m_g = 4; e0 = ext_cnt;
    ena = 1'b1; tick(); ena = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_pre_fifo", bus.val_valid, 1);
    check("rstmid_no_extract", bus.rng_extract, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ext", ext_cnt - e0, 3);
    check("rstmid_val_valid", bus.val_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_extract", bus.rng_extract, 0);
    tick();

`ifdef MKGAUSS_PERF_EN
    check("perf_rst", stall_cnt, 0);
    logn = 4'd9; m_g = 2; bus.rng = W_ONES; bus.rng_valid = 1'b0; bus.val_ready = 1'b1;
    ena = 1'b1; tick(); ena = 1'b0;
    repeat (7) tick();
    bus.rng_valid = 1'b1;
    wait_drain(100);
    check("perf_stall", stall_cnt, 7);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
